// File: rtl/rv_trace_if.sv
// Retire/drain bus of the trace buffer: retire stream in, head-of-FIFO read port out.
interface rv_trace_if #(
    parameter int XLEN = 32
);
    logic            retire_valid;
    logic [XLEN-1:0] retire_pc;
    logic [31:0]     retire_instr;
    logic            rd_ready;
    logic            rd_valid;
    logic [XLEN-1:0] rd_pc;
    logic [31:0]     rd_instr;
    logic [2:0]      rd_class;

    // Core side / debug reader drives the retire stream and rd_ready
    modport master (
        output retire_valid, retire_pc, retire_instr, rd_ready,
        input  rd_valid, rd_pc, rd_instr, rd_class
    );

    // Trace buffer side
    modport slave (
        input  retire_valid, retire_pc, retire_instr, rd_ready,
        output rd_valid, rd_pc, rd_instr, rd_class
    );
endinterface

// File: rtl/rv_trace_buffer.sv
// Retire-trace buffer: circular FIFO of retired {PC, instr}, per-class counters
// and a PC-match trigger that stops capture POST entries after the match.
module rv_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int POST  = 8,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    rv_trace_if.slave                  bus,
    input  logic                       i_clear,
    input  logic                       i_arm,
    input  logic                       i_stop,
    input  logic                       i_trig_en,
    input  logic [XLEN-1:0]            i_trig_pc,
    output logic [$clog2(DEPTH):0]     o_fill,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_overflow,
    output logic [1:0]                 o_state,
    output logic [CNT_W-1:0]           o_cycle_count,
    output logic [CNT_W-1:0]           o_instr_count,
    input  logic [2:0]                 i_class_sel,
    output logic [CNT_W-1:0]           o_class_count
);
    localparam int AW     = $clog2(DEPTH);
    localparam int FILL_W = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_TRIG  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [AW-1:0]       r_post_cnt, w_post_nxt;
    logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [FILL_W-1:0]   r_fill;
    logic                r_overflow;
    logic [CNT_W-1:0]    r_cyc_cnt, r_instr_cnt;
    logic [CNT_W-1:0]    r_cls_cnt [8];
    logic [XLEN-1:0]     r_mem_pc    [DEPTH];
    logic [31:0]         r_mem_instr [DEPTH];

    logic                w_active, w_capture, w_pop, w_full, w_empty, w_drop, w_trig_hit;
    logic [2:0]          w_cap_class;

    // Opcode to trace class; JAL/JALR and LUI/AUIPC share a class each
    function automatic logic [2:0] f_class(input logic [6:0] op);
        case (op)
            7'b0110011: f_class = 3'd0;
            7'b0010011: f_class = 3'd1;
            7'b0000011: f_class = 3'd2;
            7'b0100011: f_class = 3'd3;
            7'b1100011: f_class = 3'd4;
            7'b1101111,
            7'b1100111: f_class = 3'd5;
            7'b0110111,
            7'b0010111: f_class = 3'd6;
            default:    f_class = 3'd7;
        endcase
    endfunction

    assign w_active    = (r_state == S_ARMED) || (r_state == S_TRIG);
    assign w_capture   = bus.retire_valid && w_active;
    assign w_full      = (r_fill == FILL_W'(DEPTH));
    assign w_empty     = (r_fill == '0);
    assign w_pop       = !w_empty && bus.rd_ready;
    // Full with no pop: the oldest entry is sacrificed to make room
    assign w_drop      = w_capture && w_full && !w_pop;
    assign w_trig_hit  = w_capture && i_trig_en && (bus.retire_pc == i_trig_pc);
    assign w_cap_class = f_class(bus.retire_instr[6:0]);

    // FSM state and post-trigger countdown registers
    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_state    <= S_IDLE;
            r_post_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_post_cnt <= w_post_nxt;
        end
    end

    // FSM next state; a forced stop overrides any trigger progress
    always_comb begin
        w_state_nxt = r_state;
        w_post_nxt  = r_post_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_arm) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (w_trig_hit) begin
                    if (POST == 0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_TRIG;
                        w_post_nxt  = AW'(POST);
                    end
                end
                if (i_stop) w_state_nxt = S_DONE;
            end
            S_TRIG: begin
                if (w_capture) begin
                    w_post_nxt = r_post_cnt - 1'b1;
                    if (r_post_cnt == AW'(1)) w_state_nxt = S_DONE;
                end
                if (i_stop) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // Entry storage; stale contents are harmless since pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem_pc[r_wr_ptr]    <= bus.retire_pc;
            r_mem_instr[r_wr_ptr] <= bus.retire_instr;
        end
    end

    // Pointers, fill, overflow flag and saturating counters
    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_overflow  <= 1'b0;
            r_cyc_cnt   <= '0;
            r_instr_cnt <= '0;
            for (int k = 0; k < 8; k++) r_cls_cnt[k] <= '0;
        end else begin
            if (w_capture)        r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop || w_drop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_capture && !w_pop && !w_full) r_fill <= r_fill + 1'b1;
            else if (!w_capture && w_pop)       r_fill <= r_fill - 1'b1;
            if (w_drop) r_overflow <= 1'b1;
            if (w_active && r_cyc_cnt != '1) r_cyc_cnt <= r_cyc_cnt + 1'b1;
            if (w_capture) begin
                if (r_instr_cnt != '1) r_instr_cnt <= r_instr_cnt + 1'b1;
                if (r_cls_cnt[w_cap_class] != '1)
                    r_cls_cnt[w_cap_class] <= r_cls_cnt[w_cap_class] + 1'b1;
            end
        end
    end

    // Head of FIFO is shown directly (fall-through), zeroed while empty
    assign bus.rd_valid = !w_empty;
    assign bus.rd_pc    = w_empty ? '0 : r_mem_pc[r_rd_ptr];
    assign bus.rd_instr = w_empty ? '0 : r_mem_instr[r_rd_ptr];
    assign bus.rd_class = w_empty ? '0 : f_class(r_mem_instr[r_rd_ptr][6:0]);

    assign o_fill        = r_fill;
    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_overflow    = r_overflow;
    assign o_state       = r_state;
    assign o_cycle_count = r_cyc_cnt;
    assign o_instr_count = r_instr_cnt;
    assign o_class_count = r_cls_cnt[i_class_sel];
endmodule
